adpll_seq: RTL and testbench

Bus-master sequencer that brings up the ADPLL on a new channel without CPU involvement. On a start pulse it drives the adpll_ctr CPU register port to:
- soft-reset the loop;
- program FCW and mode;
- enable the loop;
- poll the lock and saturation status registers until lock or timeout.

It sits between the radio MAC/channel-hop logic and adpll_ctr, and shares that port with the CPU through an external mux selected by `busy`.

---
 rtl/adpll_seq.sv | 267 ++++++++++++++++++++++++++
 tb/tb_adpll_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpll_seq.sv
// ADPLL bring-up sequencer: soft-resets, programs, enables and polls the loop
// through the adpll_ctr register port while it owns the shared bus (busy).
`ifndef FCWW
`define FCWW 26
`endif
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef ADPLL_DATA_W
`define ADPLL_DATA_W 32
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 8'h00
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 8'h01
`endif
`ifndef ADPLL_SOFT_RST
`define ADPLL_SOFT_RST 8'h02
`endif
`ifndef FCW
`define FCW 8'h03
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 8'h08
`endif
`ifndef ADPLL_SAT
`define ADPLL_SAT 8'h09
`endif

module adpll_seq #(
    parameter int LOCK_TIMEOUT = 4096,
    parameter int POLL_GAP     = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [`FCWW-1:0]         fcw_in,
    input  logic [1:0]               mode_in,
    input  logic                     abort,
    output logic                     valid,
    output logic [`ADPLL_ADDR_W-1:0] address,
    output logic [`ADPLL_DATA_W-1:0] wdata,
    output logic                     wstrb,
    input  logic [1:0]               rdata,
    input  logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic                     locked,
    output logic                     timeout,
    output logic                     sat
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] SRST_HI = 4'd1;
    localparam logic [3:0] SRST_LO = 4'd2;
    localparam logic [3:0] WR_FCW  = 4'd3;
    localparam logic [3:0] WR_MODE = 4'd4;
    localparam logic [3:0] WR_EN   = 4'd5;
    localparam logic [3:0] GAP     = 4'd6;
    localparam logic [3:0] RD_LOCK = 4'd7;
    localparam logic [3:0] RD_SAT  = 4'd8;
    localparam logic [3:0] WR_DIS  = 4'd9;
    localparam logic [3:0] FIN     = 4'd10;

    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    // With no poll gap the sequencer re-reads LOCK straight away.
    localparam logic [3:0]    POLL_NEXT = (POLL_GAP == 0) ? RD_LOCK : GAP;

    logic [3:0]               state_reg, state_next;
    logic [`FCWW-1:0]         fcw_reg, fcw_next;
    logic [1:0]               mode_reg, mode_next;
    logic [TW-1:0]            tmo_reg, tmo_next;
    logic [GW-1:0]            gap_reg, gap_next;
    logic                     valid_reg, valid_next;
    logic [`ADPLL_ADDR_W-1:0] addr_reg, addr_next;
    logic [`ADPLL_DATA_W-1:0] wdata_reg, wdata_next;
    logic                     wstrb_reg, wstrb_next;
    logic                     busy_reg, busy_next;
    logic                     done_reg, done_next;
    logic                     locked_reg, locked_next;
    logic                     timeout_reg, timeout_next;
    logic                     sat_reg, sat_next;

    logic [`ADPLL_ADDR_W-1:0] req_addr;
    logic [`ADPLL_DATA_W-1:0] req_data;
    logic                     req_wr;
    logic                     tmo_hit;
    logic                     abortable;
    logic                     unused_rdata;

    assign unused_rdata = rdata[1];
    assign tmo_hit      = (tmo_reg >= TMO_LAST);
    assign abortable    = (state_reg >= SRST_HI) && (state_reg <= RD_SAT);

    // Register access issued by each bus state.
    always_comb begin
        req_wr   = 1'b1;
        req_addr = '0;
        req_data = '0;
        case (state_reg)
            SRST_HI: begin req_addr = `ADPLL_SOFT_RST; req_data = `ADPLL_DATA_W'(1); end
            SRST_LO: begin req_addr = `ADPLL_SOFT_RST; end
            WR_FCW:  begin req_addr = `FCW;           req_data = `ADPLL_DATA_W'(fcw_reg); end
            WR_MODE: begin req_addr = `ADPLL_MODE;    req_data = `ADPLL_DATA_W'(mode_reg); end
            WR_EN:   begin req_addr = `ADPLL_EN;      req_data = `ADPLL_DATA_W'(1); end
            RD_LOCK: begin req_addr = `ADPLL_LOCK;    req_wr = 1'b0; end
            RD_SAT:  begin req_addr = `ADPLL_SAT;     req_wr = 1'b0; end
            WR_DIS:  begin req_addr = `ADPLL_EN; end
            default: ;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        fcw_next     = fcw_reg;
        mode_next    = mode_reg;
        tmo_next     = tmo_reg;
        gap_next     = gap_reg;
        valid_next   = valid_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        locked_next  = locked_reg;
        timeout_next = timeout_reg;
        sat_next     = sat_reg;

        if ((state_reg == GAP || state_reg == RD_LOCK) && !tmo_hit) begin
            tmo_next = tmo_reg + TW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    fcw_next     = fcw_in;
                    mode_next    = mode_in;
                    locked_next  = 1'b0;
                    timeout_next = 1'b0;
                    sat_next     = 1'b0;
                    busy_next    = 1'b1;
                    state_next   = SRST_HI;
                end
            end
            GAP: begin
                if (abort) begin
                    state_next = WR_DIS;
                end else if (tmo_hit) begin
                    timeout_next = 1'b1;
                    state_next   = WR_DIS;
                end else if (gap_reg == GAP_LAST) begin
                    state_next = RD_LOCK;
                end else begin
                    gap_next = gap_reg + GW'(1);
                end
            end
            FIN: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                // Bus states: one idle cycle to raise valid, then hold until ready.
                if (!valid_reg) begin
                    if (abortable && abort) begin
                        state_next = WR_DIS;
                    end else if (state_reg == RD_LOCK && tmo_hit) begin
                        timeout_next = 1'b1;
                        state_next   = WR_DIS;
                    end else begin
                        valid_next = 1'b1;
                        addr_next  = req_addr;
                        wdata_next = req_data;
                        wstrb_next = req_wr;
                    end
                end else if (ready) begin
                    valid_next = 1'b0;
                    addr_next  = '0;
                    wdata_next = '0;
                    wstrb_next = 1'b0;
                    if (abortable && abort) begin
                        state_next = WR_DIS;
                    end else begin
                        case (state_reg)
                            SRST_HI: state_next = SRST_LO;
                            SRST_LO: state_next = WR_FCW;
                            WR_FCW:  state_next = WR_MODE;
                            WR_MODE: state_next = WR_EN;
                            WR_EN: begin
                                tmo_next   = '0;
                                gap_next   = '0;
                                state_next = POLL_NEXT;
                            end
                            RD_LOCK: begin
                                if (rdata[0]) begin
                                    state_next = RD_SAT;
                                end else begin
                                    gap_next   = '0;
                                    state_next = POLL_NEXT;
                                end
                            end
                            RD_SAT: begin
                                sat_next    = rdata[0];
                                locked_next = 1'b1;
                                done_next   = 1'b1;
                                state_next  = FIN;
                            end
                            WR_DIS: begin
                                done_next  = 1'b1;
                                state_next = FIN;
                            end
                            default: state_next = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            fcw_reg     <= '0;
            mode_reg    <= '0;
            tmo_reg     <= '0;
            gap_reg     <= '0;
            valid_reg   <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            locked_reg  <= 1'b0;
            timeout_reg <= 1'b0;
            sat_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            fcw_reg     <= fcw_next;
            mode_reg    <= mode_next;
            tmo_reg     <= tmo_next;
            gap_reg     <= gap_next;
            valid_reg   <= valid_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            locked_reg  <= locked_next;
            timeout_reg <= timeout_next;
            sat_reg     <= sat_next;
        end
    end

    assign valid   = valid_reg;
    assign address = addr_reg;
    assign wdata   = wdata_reg;
    assign wstrb   = wstrb_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign locked  = locked_reg;
    assign timeout = timeout_reg;
    assign sat     = sat_reg;

endmodule

// File: tb/tb_adpll_seq.sv
// Bench for adpll_seq: register-port responder with programmable ready delay
// and lock/SAT answers, transaction log, vector table and corner sequences.
`ifndef FCWW
`define FCWW 26
`endif
`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef ADPLL_DATA_W
`define ADPLL_DATA_W 32
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 8'h00
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 8'h01
`endif
`ifndef ADPLL_SOFT_RST
`define ADPLL_SOFT_RST 8'h02
`endif
`ifndef FCW
`define FCW 8'h03
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 8'h08
`endif
`ifndef ADPLL_SAT
`define ADPLL_SAT 8'h09
`endif

module tb_adpll_seq;
    localparam int PG = 2;
    localparam int LT = 64;
    localparam int FW = `FCWW;
    localparam int AW = `ADPLL_ADDR_W;
    localparam int DW = `ADPLL_DATA_W;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } xact_t;

    typedef struct {
        logic [FW-1:0] fcw;
        logic [1:0]    mode;
        int            lock_on;
        logic          sat_v;
        int            delay;
        logic          exp_locked;
        logic          exp_sat;
        logic          exp_timeout;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [FW-1:0] fcw_in;
    logic [1:0]    mode_in;
    logic          valid, wstrb, ready, busy, done, locked, timeout, sat;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;
    logic [1:0]    rdata;

    always #5 clk = ~clk;

    adpll_seq #(.LOCK_TIMEOUT(LT), .POLL_GAP(PG)) dut (
        .clk(clk), .rst(rst), .start(start), .fcw_in(fcw_in), .mode_in(mode_in),
        .abort(abort), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .busy(busy), .done(done),
        .locked(locked), .timeout(timeout), .sat(sat)
    );

    int tests = 0;
    int fails = 0;

    // Responder: ready after ready_delay wait cycles; LOCK answers 1 from the lock_on-th read.
    int   ready_delay = 0;
    int   lock_on = 0;
    logic sat_val = 1'b0;
    int   reads_base = 0;
    int   wcnt = 0;
    int   lock_reads = 0;

    assign ready = valid && (wcnt >= ready_delay);

    always @* begin
        rdata = 2'b00;
        if (address == `ADPLL_LOCK)
            rdata[0] = (lock_on != 0) && ((lock_reads - reads_base + 1) >= lock_on);
        else if (address == `ADPLL_SAT)
            rdata[0] = sat_val;
    end

    always @(posedge clk) begin
        if (rst || !valid || ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (valid && ready && !wstrb && address == `ADPLL_LOCK) lock_reads <= lock_reads + 1;
    end

    // Bus monitor: logs completed transactions, counts handshake violations and done pulses.
    xact_t         log_q[$];
    int            viol_cnt = 0;
    int            done_cnt = 0;
    logic          prev_valid = 1'b0, prev_cmpl = 1'b0, prev_wstrb = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wdata = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_cmpl  <= 1'b0;
        end else begin
            viol_cnt <= viol_cnt
                + int'(prev_valid && !prev_cmpl && (!valid || address != prev_addr
                       || wdata != prev_wdata || wstrb != prev_wstrb))
                + int'(prev_valid && prev_cmpl && valid)
                + int'(!valid && (address != '0 || wdata != '0))
                + int'(valid && !wstrb && wdata != '0);
            if (valid && ready) begin
                log_q.push_back({wstrb, address, wdata});
                $display("[TB] bus %s addr=%h wdata=%h rdata=%0d", wstrb ? "WR" : "RD",
                         address, wdata, rdata[0]);
            end
            if (done) done_cnt <= done_cnt + 1;
            prev_valid <= valid;
            prev_cmpl  <= valid && ready;
            prev_addr  <= address;
            prev_wdata <= wdata;
            prev_wstrb <= wstrb;
        end
    end

    xact_t exp_q[$];
    vec_t  vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        xact_t x;
        x.wr = wr; x.addr = a; x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic exp_writes(input logic [FW-1:0] f, input logic [1:0] m);
        exp_q.delete();
        exp_push(1'b1, `ADPLL_SOFT_RST, DW'(1));
        exp_push(1'b1, `ADPLL_SOFT_RST, '0);
        exp_push(1'b1, `FCW, DW'(f));
        exp_push(1'b1, `ADPLL_MODE, DW'(m));
        exp_push(1'b1, `ADPLL_EN, DW'(1));
    endtask

    task automatic chk_log(input string name, input int base);
        chk({name, "_len"}, log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < log_q.size())
                chk($sformatf("%s_xact%0d", name, i), log_q[base + i], exp_q[i]);
        end
    endtask

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, "_done_seen"}, done, 1'b1);
    endtask

    task automatic pulse_start(input logic [FW-1:0] f, input logic [1:0] m);
        fcw_in = f; mode_in = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_case(input string name, input vec_t v);
        int base, dbase, vbase, cyc, t, n, bad;
        xact_t x;
        $display("[TB] %s fcw=%h mode=%0d lock_on=%0d sat=%0d delay=%0d", name, v.fcw,
                 v.mode, v.lock_on, v.sat_v, v.delay);
        ready_delay = v.delay; lock_on = v.lock_on; sat_val = v.sat_v; reads_base = lock_reads;
        base = log_q.size(); dbase = done_cnt; vbase = viol_cnt;
        pulse_start(v.fcw, v.mode);
        chk({name, "_busy_on_start"}, busy, 1'b1);
        chk({name, "_flags_cleared"}, {locked, timeout, sat}, 3'b000);
        wait_done(name, cyc);
        chk({name, "_locked"}, locked, v.exp_locked);
        chk({name, "_sat"}, sat, v.exp_sat);
        chk({name, "_timeout"}, timeout, v.exp_timeout);
        chk({name, "_busy_in_fin"}, busy, 1'b1);
        t = 2 + v.delay;
        if (v.exp_locked) begin
            chk({name, "_done_cycle"}, cyc, 6 * t + v.lock_on * (PG + t));
        end else begin
            chk({name, "_tmo_not_early"}, cyc >= 6 * t + LT - 1, 1'b1);
            chk({name, "_tmo_not_late"}, cyc <= 7 * t + LT + PG, 1'b1);
        end
        @(posedge clk); #1;
        chk({name, "_done_one_cycle"}, done, 1'b0);
        chk({name, "_busy_after_fin"}, busy, 1'b0);
        chk({name, "_done_pulses"}, done_cnt - dbase, 1);
        chk({name, "_protocol"}, viol_cnt - vbase, 0);
        exp_writes(v.fcw, v.mode);
        if (v.exp_locked) begin
            for (int i = 0; i < v.lock_on; i++) exp_push(1'b0, `ADPLL_LOCK, '0);
            exp_push(1'b0, `ADPLL_SAT, '0);
            chk_log(name, base);
        end else begin
            exp_push(1'b1, `ADPLL_EN, '0);
            n = log_q.size() - base;
            chk({name, "_tmo_len"}, n >= 7, 1'b1);
            bad = 0;
            for (int i = 0; i < n; i++) begin
                x = log_q[base + i];
                if (i < 5) begin
                    if (x !== exp_q[i]) bad++;
                end else if (i == n - 1) begin
                    if (x !== exp_q[5]) bad++;
                end else if (x.wr || x.addr != `ADPLL_LOCK) begin
                    bad++;
                end
            end
            chk({name, "_tmo_log"}, bad, 0);
        end
    endtask

    initial begin
        int   base, dbase, vbase, cyc;
        vec_t v;

        rst = 1'b1; start = 1'b0; abort = 1'b0; fcw_in = '0; mode_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", valid, 1'b0);
        chk("reset_address", address, '0);
        chk("reset_wdata", wdata, '0);
        chk("reset_wstrb", wstrb, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_flags", {locked, timeout, sat}, 3'b000);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors, then random ones with expectations from the outcome rules.
        vecs.push_back('{26'h2620000, 2'd1, 3, 1'b0, 0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{26'h3ffffff, 2'd2, 1, 1'b1, 0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{26'h0000001, 2'd3, 2, 1'b1, 3, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{26'h1234567, 2'd0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{26'h0abcdef, 2'd1, 4, 1'b0, 1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{26'h2aaaaaa, 2'd2, 0, 1'b1, 2, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{26'h1555555, 2'd3, 1, 1'b1, 3, 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 6; i++) begin
            v.fcw     = FW'($urandom);
            v.mode    = 2'($urandom);
            v.lock_on = $urandom_range(0, 5);
            v.sat_v   = 1'($urandom);
            v.delay   = $urandom_range(0, 3);
            v.exp_locked  = (v.lock_on != 0);
            v.exp_sat     = (v.lock_on != 0) && v.sat_v;
            v.exp_timeout = (v.lock_on == 0);
            vecs.push_back(v);
        end
        for (int i = 0; i < vecs.size(); i++) run_case($sformatf("vec%0d", i), vecs[i]);

        // Abort while the FCW write waits for ready.
        $display("[TB] abort during WR_FCW");
        ready_delay = 3; lock_on = 1; sat_val = 1'b0; reads_base = lock_reads;
        base = log_q.size(); dbase = done_cnt; vbase = viol_cnt;
        pulse_start(26'h155aa33, 2'd2);
        cyc = 0;
        while (!(valid && address == `FCW) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_fcw_in_flight", valid && address == `FCW, 1'b1);
        abort = 1'b1;
        wait_done("abort", cyc);
        chk("abort_flags", {locked, timeout, sat}, 3'b000);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy_after", busy, 1'b0);
        chk("abort_done_pulses", done_cnt - dbase, 1);
        chk("abort_protocol", viol_cnt - vbase, 0);
        exp_writes(26'h155aa33, 2'd2);
        exp_q.pop_back();
        exp_q.pop_back();
        exp_push(1'b1, `ADPLL_EN, '0);
        chk_log("abort", base);

        // start while busy and on the FIN cycle are both ignored.
        $display("[TB] start while busy / on FIN");
        ready_delay = 0; lock_on = 2; sat_val = 1'b1; reads_base = lock_reads;
        base = log_q.size(); dbase = done_cnt; vbase = viol_cnt;
        pulse_start(26'h0c0ffee, 2'd1);
        repeat (4) begin @(posedge clk); #1; end
        pulse_start(26'h3ff00ff, 2'd3);
        wait_done("ign", cyc);
        pulse_start(26'h3ff00ff, 2'd3);
        chk("ign_fin_start_busy", busy, 1'b0);
        chk("ign_fin_start_done", done, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        chk("ign_idle_busy", busy, 1'b0);
        chk("ign_sticky", {locked, timeout, sat}, 3'b101);
        chk("ign_done_pulses", done_cnt - dbase, 1);
        chk("ign_protocol", viol_cnt - vbase, 0);
        exp_writes(26'h0c0ffee, 2'd1);
        exp_push(1'b0, `ADPLL_LOCK, '0);
        exp_push(1'b0, `ADPLL_LOCK, '0);
        exp_push(1'b0, `ADPLL_SAT, '0);
        chk_log("ign", base);

        // Reset in the middle of a LOCK read, then a full clean sequence.
        $display("[TB] reset during RD_LOCK");
        ready_delay = 3; lock_on = 0; sat_val = 1'b0; reads_base = lock_reads;
        pulse_start(26'h0777777, 2'd0);
        cyc = 0;
        while (!(valid && address == `ADPLL_LOCK) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst_lock_in_flight", valid && address == `ADPLL_LOCK, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_valid", valid, 1'b0);
        chk("rst_bus", {address, wdata}, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {done, locked, timeout, sat}, 4'b0000);
        @(posedge clk); #1;
        v = '{26'h2345678, 2'd1, 2, 1'b1, 1, 1'b1, 1'b1, 1'b0};
        run_case("after_rst", v);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
